uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
UART serial transmitter driven by the UART register block's configuration and control outputs. It accepts a start request, latches the byte and frame format, and serialises start/data/parity/stop bits onto the tx line. It reports completion back to the register block: a one-cycle start_tx_down pulse on acceptance and a level tx_done on completion.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit period (100 MHz / 115200); legal range 2..65535.
CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT-1.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to send; only the low 5..8 bits are used, per data_bit_num
data_bit_num  input  2  data width: 00=5, 01=6, 10=7, 11=8 bits
stop_bit_num  input  1  0 = one stop bit, 1 = two stop bits
parity_en  input  1  1 = insert a parity bit after the data bits
parity_type  input  1  0 = even parity, 1 = odd parity
start_tx  input  1  level request to send a frame; held high until start_tx_down
start_tx_down  output  1  one-cycle pulse; the request is accepted
tx_done  output  1  sticky level; the last frame has completed
tx_busy  output  1  high while a frame is in progress
tx  output  1  serial line; idle high

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: tx=1, tx_done=0, start_tx_down=0, tx_busy=0, state=IDLE, counters=0.
- All outputs are registered.
- States: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE.
- IDLE:
  - On a clk edge with start_tx=1, the block latches tx_data, data_bit_num, stop_bit_num, parity_en and parity_type into shadow registers.
  - At that same edge it sets start_tx_down=1 (for exactly one cycle), tx_done=0, tx_busy=1, tx=0, and moves to START.
- Latency: tx falls one cycle after start_tx is sampled.
- Bit timing:
  - Each bit holds tx constant for exactly CLKS_PER_BIT cycles.
  - bit_cnt counts 0..CLKS_PER_BIT-1; the bit or state advances when bit_cnt = CLKS_PER_BIT-1.
- START: tx=0 for one bit period.
- DATA:
  - Sends N = 5 + data_bit_num bits, LSB first, from the shadow byte.
  - An index counter runs 0..N-1.
  - Bits above N-1 are never sent.
- PARITY:
  - Bit value p = XOR of the N sent data bits, XOR parity_type.
  - Even parity gives an even total number of ones; odd parity gives an odd total.
- STOP:
  - tx=1 for 1 or 2 bit periods, per the shadow stop_bit_num.
  - At the edge that ends the last stop period: state=IDLE, tx_busy=0, tx_done=1, tx stays 1.
- Frame length: CLKS_PER_BIT × (1 + N + parity_en + 1 + stop_bit_num) cycles, measured from the first cycle of tx=0.
- tx_done stays high until the next start is accepted; it clears at the same edge start_tx_down pulses.
- Back-to-back frames: if start_tx=1 in the first IDLE cycle after STOP, the next frame is accepted immediately. There is no idle gap beyond the stop bits.
- start_tx while not IDLE:
  - The request is ignored; start_tx_down stays 0.
  - The request remains pending and is accepted once the block is back in IDLE.
- Changes to tx_data or configuration inputs mid-frame have no effect on the current frame because the frame uses the shadow registers.
- Reset mid-frame: outputs return to their reset values asynchronously and the frame is abandoned; no tx_done.
- When start_tx_down and start_tx are both high in the acceptance cycle, exactly one frame is sent. The register block clears start_tx on start_tx_down.

Test Plan:
- Reset: assert rst_n=0 mid-idle and mid-frame -> tx=1, tx_busy=0, tx_done=0, start_tx_down=0 immediately; no further activity after release until start_tx.
- 8N1, CLKS_PER_BIT=4, tx_data=0x55, start_tx=1 -> start_tx_down pulses 1 cycle; tx reads 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; tx_done=1 at cycle 40; tx_busy high for 40 cycles.
- 5 bits, even parity, 2 stop bits (data_bit_num=00, parity_en=1, parity_type=0, stop_bit_num=1), tx_data=0xA7 -> data bits 1,1,1,0,0; parity=1; stop=1,1; frame is 36 cycles.
- 7 bits, odd parity, 1 stop bit, tx_data=0x41 -> data bits 1,0,0,0,0,0,1; parity=1; frame is 40 cycles; with parity_type=0 the parity bit is 0.
- Change tx_data to 0xFF and data_bit_num to 00 during DATA, and pulse start_tx mid-frame -> current frame is unchanged and no start_tx_down mid-frame. The held start_tx is accepted in the first IDLE cycle, with the new frame's start bit immediately after the stop bit.
- Two back-to-back requests, 8N1 (0x00 then 0xFF) -> tx_done clears at the second acceptance; no gap between the first stop bit and the second start bit; tx_done=1 after the second frame (80 cycles total).

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Register-block <-> transmitter handshake and frame-format bundle.
// The register block drives the configuration and the request; the core drives the line and status.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       start_tx;
    logic       start_tx_down;
    logic       tx_done;
    logic       tx_busy;
    logic       tx;

    modport master (
        output tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
        input  start_tx_down, tx_done, tx_busy, tx
    );

    modport slave (
        input  tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
        output start_tx_down, tx_done, tx_busy, tx
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: latches a byte and frame format on request and serialises
// start / 5..8 data (LSB first) / optional parity / 1..2 stop bits onto tx.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       nbits_q, nbits_d;
    logic             stop2_q, stop2_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             down_q, down_d;
    logic             busy_q, busy_d;

    logic             bit_end;
    logic [2:0]       last_idx;
    logic [7:0]       data_mask;
    logic             par_bit;

    assign bit_end   = (bit_cnt_q == BIT_LAST);
    assign last_idx  = {1'b0, nbits_q} + 3'd4;
    // Unused high bits of the shadow byte must not leak into parity.
    assign data_mask = 8'hFF >> (3'd3 - {1'b0, nbits_q});
    assign par_bit   = (^(data_q & data_mask)) ^ par_type_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        nbits_d    = nbits_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        tx_d       = tx_q;
        done_d     = done_q;
        down_d     = 1'b0;
        busy_d     = busy_q;

        if (state_q != IDLE)
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start_tx) begin
                    data_d     = bus.tx_data;
                    nbits_d    = bus.data_bit_num;
                    stop2_d    = bus.stop_bit_num;
                    par_en_d   = bus.parity_en;
                    par_type_d = bus.parity_type;
                    down_d     = 1'b1;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    bit_cnt_d  = '0;
                    idx_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = data_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                // idx_q counts stop periods already finished within STOP.
                if (bit_end) begin
                    if (idx_q[0] == stop2_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            nbits_q    <= '0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            down_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            nbits_q    <= nbits_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            down_q     <= down_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx            = tx_q;
    assign bus.tx_done       = done_q;
    assign bus.start_tx_down = down_q;
    assign bus.tx_busy       = busy_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Randomised + directed bench for uart_tx_core against a bit-list frame model.
module tb_uart_tx_core;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if u_if();

    uart_tx_core #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                           input logic pe, input logic pt);
        u_if.tx_data      = d;
        u_if.data_bit_num = dbn;
        u_if.stop_bit_num = sb;
        u_if.parity_en    = pe;
        u_if.parity_type  = pt;
    endtask

    // Reference: the frame as a list of line levels, one entry per bit period.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                               input logic pe, input logic pt, output int nb, output bit bits[16]);
        int n, ones;
        n = 5 + int'(dbn);
        ones = 0;
        nb = 0;
        bits[nb++] = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[nb++] = d[i];
            if (d[i]) ones++;
        end
        // Parity bit makes the total count of ones even (pt=0) or odd (pt=1).
        if (pe) bits[nb++] = ((ones % 2) == 1) ^ pt;
        bits[nb++] = 1'b1;
        if (sb) bits[nb++] = 1'b1;
    endtask

    // Requests a frame and checks it cycle by cycle; optionally raises a new
    // request with new configuration in the middle of the frame.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                             input logic pe, input logic pt,
                             input bit pend, input logic [7:0] nd, input logic [1:0] ndbn);
        int k, nb, len;
        bit bits[16];
        set_cfg(d, dbn, sb, pe, pt);
        u_if.start_tx = 1'b1;
        k = 0;
        @(negedge clk);
        while (!u_if.start_tx_down && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept_latency", k, 0);
        if (!u_if.start_tx_down) begin
            u_if.start_tx = 1'b0;
            return;
        end
        chk("done_clr", u_if.tx_done, 0);
        u_if.start_tx = 1'b0;
        build_frame(d, dbn, sb, pe, pt, nb, bits);
        len = nb * CPB;
        for (int c = 0; c < len; c++) begin
            chk($sformatf("tx_c%0d", c), u_if.tx, bits[c / CPB]);
            chk("busy_in_frame", u_if.tx_busy, 1);
            chk("done_in_frame", u_if.tx_done, 0);
            if (c > 0) chk("down_one_cycle", u_if.start_tx_down, 0);
            if (pend && c == 2 * CPB) begin
                u_if.tx_data      = nd;
                u_if.data_bit_num = ndbn;
                u_if.start_tx     = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_busy", u_if.tx_busy, 0);
        chk("end_done", u_if.tx_done, 1);
        chk("end_tx", u_if.tx, 1);
        chk("end_down", u_if.start_tx_down, 0);
    endtask

    initial begin
        u_if.start_tx = 1'b0;
        set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx", u_if.tx, 1);
        chk("rst_busy", u_if.tx_busy, 0);
        chk("rst_done", u_if.tx_done, 0);
        chk("rst_down", u_if.start_tx_down, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_tx", u_if.tx, 1);
        chk("idle_busy", u_if.tx_busy, 0);

        // Directed formats from the plan.
        run_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        run_frame(8'hA7, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
        run_frame(8'h41, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
        run_frame(8'h41, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);

        // Mid-frame config change + pending request, then the held request.
        run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b00);
        run_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);

        // Back-to-back 8N1.
        run_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b11);
        run_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] rd;
            logic [1:0] rdbn;
            logic rsb, rpe, rpt;
            rd   = 8'($urandom);
            rdbn = 2'($urandom_range(0, 3));
            rsb  = 1'($urandom_range(0, 1));
            rpe  = 1'($urandom_range(0, 1));
            rpt  = 1'($urandom_range(0, 1));
            run_frame(rd, rdbn, rsb, rpe, rpt, 1'b0, 8'h00, 2'b00);
        end

        // Reset in idle with tx_done set.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("idle_rst_done", u_if.tx_done, 0);
        chk("idle_rst_tx", u_if.tx, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a frame: everything drops immediately, frame abandoned.
        set_cfg(8'h00, 2'b11, 1'b0, 1'b1, 1'b0);
        u_if.start_tx = 1'b1;
        @(negedge clk);
        chk("mid_accept", u_if.start_tx_down, 1);
        u_if.start_tx = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", u_if.tx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", u_if.tx, 1);
        chk("mid_rst_busy", u_if.tx_busy, 0);
        chk("mid_rst_done", u_if.tx_done, 0);
        chk("mid_rst_down", u_if.start_tx_down, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 14 * CPB; c++) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.tx_busy !== 1'b0 || u_if.tx_done !== 1'b0) begin
                chk("post_rst_quiet", {u_if.tx, u_if.tx_busy, u_if.tx_done}, 3'b100);
                break;
            end
        end
        chk("post_rst_tx", u_if.tx, 1);
        chk("post_rst_done", u_if.tx_done, 0);

        run_frame(8'h96, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
